// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared state encoding and default sizes for the FFT frame controller
// Contents: state_t (ST_IDLE..ST_HOLD), default N_POINTS/IDX_W/EXP_W, idle bin code.
package fft_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_UNLOAD = 3'd3,
        ST_DONE   = 3'd4,
        ST_HOLD   = 3'd5
    } state_t;

    localparam int DEF_N_POINTS = 4096;
    localparam int DEF_IDX_W    = 13;
    localparam int DEF_EXP_W    = 6;

    // bin_idx value that tells downstream no bin window is active
    localparam int IDX_IDLE     = DEF_N_POINTS;

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// rtl/fft_frame_ctrl_if.sv - sample sink, spectrum source and bin output bundle
// Ports (master = controller side):
//   in : adc_valid, sink_ready, source_valid, source_sop, source_eop, source_exp
//   out: sink_valid, sink_sop, sink_eop, bin_idx, exp_out, frame_done
interface fft_frame_ctrl_if #(
    parameter int IDX_W = 13,
    parameter int EXP_W = 6
);
    logic             adc_valid;
    logic             sink_ready;
    logic             sink_valid;
    logic             sink_sop;
    logic             sink_eop;
    logic             source_valid;
    logic             source_sop;
    logic             source_eop;
    logic [EXP_W-1:0] source_exp;
    logic [IDX_W-1:0] bin_idx;
    logic [EXP_W-1:0] exp_out;
    logic             frame_done;

    modport master (
        input  adc_valid, sink_ready, source_valid, source_sop, source_eop, source_exp,
        output sink_valid, sink_sop, sink_eop, bin_idx, exp_out, frame_done
    );

    modport slave (
        output adc_valid, sink_ready, source_valid, source_sop, source_eop, source_exp,
        input  sink_valid, sink_sop, sink_eop, bin_idx, exp_out, frame_done
    );
endinterface

// File: rtl/fft_bin_counter.sv
// rtl/fft_bin_counter.sv - loadable enable-gated up counter with terminal-count flag
// Ports: clk, rst_n, load/load_val (priority over en), en, count, tc (count == TC)
module fft_bin_counter #(
    parameter int W       = 13,
    parameter int TC      = 4095,
    parameter int RST_VAL = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= W'(RST_VAL);
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == W'(TC));
endmodule

// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - sequences one FFT frame: load samples, await spectrum, walk bins
// Ports: clk, rst_n (async, active low), run (free-running level), start (one-shot pulse),
//        bus (fft_frame_ctrl_if.master), busy, err (abort pulse), state_dbg (state code)
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int N_POINTS = DEF_N_POINTS,
    parameter int IDX_W    = DEF_IDX_W,
    parameter int EXP_W    = DEF_EXP_W,
    parameter int TIMEOUT  = 65535,
    parameter int HOLD_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             start,
    fft_frame_ctrl_if.master bus,
    output logic             busy,
    output logic             err,
    output logic [2:0]       state_dbg
);
    localparam logic [IDX_W-1:0]  IDX_IDLE_V = IDX_W'(N_POINTS);
    localparam logic [15:0]       TMO_LAST   = 16'(TIMEOUT - 1);
    localparam logic [15:0]       TMO_MAX    = 16'(TIMEOUT);
    localparam int                HOLD_W     = $clog2(HOLD_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYC - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   smp_cnt, bin_cnt, bin_load_val;
    logic               smp_last, bin_last, bin_load;
    logic [15:0]        tmo_cnt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [EXP_W-1:0]   exp_q;
    logic               err_q;
    logic               accept, sop_hit, timeout, beat, unload_err, last_beat, abort;

    assign accept     = (state_q == ST_LOAD) && bus.adc_valid && bus.sink_ready;
    assign sop_hit    = (state_q == ST_WAIT) && bus.source_valid && bus.source_sop;
    assign timeout    = (state_q == ST_WAIT) && !sop_hit && (tmo_cnt == TMO_LAST);
    assign beat       = (state_q == ST_UNLOAD) && bus.source_valid;
    // a fresh sop, or an eop before the final bin, means the core lost framing
    assign unload_err = beat && (bus.source_sop || (bus.source_eop && !bin_last));
    assign last_beat  = beat && bin_last && !unload_err;
    assign abort      = timeout || unload_err;

    // sample counter: held at zero outside LOAD so every frame starts at sample 0
    fft_bin_counter #(.W(IDX_W), .TC(N_POINTS - 1), .RST_VAL(0)) u_smp_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state_q != ST_LOAD),
        .load_val ('0),
        .en       (accept),
        .count    (smp_cnt),
        .tc       (smp_last)
    );

    // bin counter doubles as bin_idx; parked at the idle code outside a bin window
    assign bin_load     = sop_hit || abort || last_beat || (state_q == ST_DONE);
    assign bin_load_val = sop_hit ? '0 : IDX_IDLE_V;

    fft_bin_counter #(.W(IDX_W), .TC(N_POINTS - 1), .RST_VAL(N_POINTS)) u_bin_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (bin_load),
        .load_val (bin_load_val),
        .en       (beat),
        .count    (bin_cnt),
        .tc       (bin_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            tmo_cnt  <= '0;
            hold_cnt <= '0;
            exp_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= abort;
            if (sop_hit) begin
                exp_q <= bus.source_exp;
            end
            if (state_q != ST_WAIT) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != TMO_MAX) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
            if (state_q != ST_HOLD) begin
                hold_cnt <= '0;
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start || run) state_d = ST_LOAD;
            ST_LOAD:   if (accept && smp_last) state_d = ST_WAIT;
            ST_WAIT: begin
                if (sop_hit)      state_d = ST_UNLOAD;
                else if (timeout) state_d = ST_IDLE;
            end
            ST_UNLOAD: begin
                if (unload_err)     state_d = ST_IDLE;
                else if (last_beat) state_d = ST_DONE;
            end
            // run is sampled only at frame boundaries, so a mid-frame drop finishes the frame
            ST_DONE:   state_d = run ? ST_HOLD : ST_IDLE;
            ST_HOLD:   if (hold_cnt == HOLD_LAST) state_d = run ? ST_LOAD : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign bus.sink_valid = accept;
    assign bus.sink_sop   = accept && (smp_cnt == '0);
    assign bus.sink_eop   = accept && smp_last;
    assign bus.bin_idx    = bin_cnt;
    assign bus.exp_out    = exp_q;
    assign bus.frame_done = (state_q == ST_DONE);
    assign busy           = (state_q != ST_IDLE);
    assign err            = err_q;
    assign state_dbg      = state_q;
endmodule
